lvds_word_deframer: RTL and testbench
=====================================

# lvds_word_deframer

Recovers 12-bit host words from the serial host link (`LVDS_IN[1]`) inside `breakout`, downstream of the LVDS input pins and upstream of the link decode and `link_status` logic. The block shifts in one bit per qualified clock and hunts for the sync word `12'b0001_0000_0000`. It verifies frame alignment, then emits the data words of each frame with their index, and reports lock and sync-error status.

## Interface
- `DATA_WORDS`, 4: data words following each sync word per frame (≥1).
- `LOCK_SYNCS`, 2: consecutive correct sync words required to assert lock, including the one found in hunt (≥1).
- `MISS_MAX`, 3: consecutive missed sync words while locked that drop lock (≥1).
- `clk` input 1: link sample clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `bit_en` input 1: `sdata` holds a valid bit this cycle.
- `sdata` input 1: serial bit, MSB first.
- `word_data` output 12: last completed data word.
- `word_valid` output 1: one-cycle pulse, `word_data`/`word_idx` valid.
- `word_idx` output 3: data word index within frame, 0..`DATA_WORDS`-1.
- `frame_start` output 1: one-cycle pulse on acceptance of a correct sync word while locked.
- `locked` output 1: frame alignment established.
- `sync_err` output 8: saturating count of sync misses while locked.

## Operation
- Shift register `sr[11:0]`: on `bit_en`, `sr <= {sr[10:0], sdata}`. Define `next_word = {sr[10:0], sdata}`. When `bit_en`=0, no state changes and all pulses are low.
- Three states: HUNT, VERIFY, LOCKED.
- HUNT: on each `bit_en`, if `next_word == SYNC`, then go to VERIFY with `bit_cnt=0`, `slot=1`, and `sync_ok=1`. With `LOCK_SYNCS`=1, go directly to LOCKED instead.
- VERIFY/LOCKED: `bit_cnt` counts 0..11 on `bit_en`. On the 12th bit (`bit_cnt==11`), the word completes, `bit_cnt` wraps to 0, and `slot` advances 0..`DATA_WORDS` then wraps to 0. Slot 0 is the sync position.
- VERIFY, sync slot:
  - Match: increment `sync_ok`. Reaching `LOCK_SYNCS` goes to LOCKED, raises `locked`, and pulses `frame_start`.
  - Mismatch: go to HUNT and clear `sync_ok`.
- VERIFY, data slots: no outputs.
- LOCKED, sync slot:
  - Match: clear `miss_cnt` and pulse `frame_start`.
  - Mismatch: increment `miss_cnt` and `sync_err` (`sync_err` saturates at 255); no `frame_start`. If `miss_cnt` reaches `MISS_MAX`, go to HUNT, drop `locked`, clear `miss_cnt`.
  - `sync_err` is cleared only by reset.
- LOCKED, data slot k (1..`DATA_WORDS`): set `word_data = next_word`, `word_idx = k-1`, pulse `word_valid`. Data emission continues through missed syncs; the flywheel keeps alignment.
- Sync words are never emitted on `word_data`.
- Re-entering HUNT from LOCKED does not clear `sr`. A match can occur on the very next `bit_en`.

## Timing
- All outputs are registered. `word_valid`/`frame_start` are high for the single cycle after the edge that accepted the 12th bit.
- Latency: 1 clk from the last bit's `bit_en` edge to the output pulse.
- `locked` rises in the same cycle as the `frame_start` that completes verification. It falls in the cycle after the edge that registers the `MISS_MAX`-th miss.
- Minimum word spacing is 12 `bit_en` cycles. Back-to-back `bit_en` every clk is supported at full rate.
- Reset values: `word_data`=0, `word_valid`=0, `word_idx`=0, `frame_start`=0, `locked`=0, `sync_err`=0. Internally `sr`=0, state HUNT, all counters 0.
- Reset asserted mid-word or mid-frame: the next cycle is HUNT with everything cleared; the partial word is discarded. Reset wins over `bit_en` in the same cycle.
- `word_data` holds its value between pulses.

## Structure
- Shared package `breakout_pkg`:
  - `WORD_W=12`
  - `SYNC_WORD=12'h100`
  - `deframer_state_t` enum (HUNT, VERIFY, LOCKED)
  - `link_led`/`link_status` encodings consume `locked` and `sync_err`.
- One sub-module, `bit_word_shifter`, owns `sr`, `bit_cnt`, and the `next_word`/`word_done` strobes.
- The parent owns the FSM, slot counter, and outputs.

## Test plan
- **Continuous sync stream:** `bit_en`=1, rotating pattern `000100000000` (every word sync), `DATA_WORDS`=0 variant disallowed; use `DATA_WORDS`=1 with data `12'h7F0`.
  - `locked` is high after 2 frames.
  - `word_valid` pulses every 24 clks with `word_data=12'h7F0`, `word_idx=0`.
- **Framed data, default params:** frames of SYNC, `12'h7F0`, `12'hA0F`, `12'hFFF`, `12'h100`.
  - Lock at the second `frame_start`.
  - Then 4 `word_valid` pulses per frame with `word_idx` 0..3 and exactly those values, including `12'h100` as data in slot 4.
- **Sparse bit_en:** `bit_en` high 1 clk in 3.
  - Same words as the framed-data case; pulses spaced 36 clks.
  - No output activity in gap cycles.
- **Sync loss:** after lock, corrupt 2 consecutive syncs, then restore.
  - `sync_err`=2, `locked` stays 1, data keeps flowing.
  - Corrupt 3 consecutive syncs: `locked`=0 after the third, `sync_err`=5; re-lock after 2 good syncs.
- **Bit slip:** insert one extra bit after lock.
  - Misses accumulate; lock drops after 3 frames.
  - Re-hunt aligns to the new boundary, and the correct words resume.
- **Reset mid-frame:** assert `reset` for 1 clk at bit 5 of data word 2.
  - All outputs are 0 the next cycle.
  - No `word_valid` until re-lock.
  - `sync_err`=0.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout host-link path: word format, sync pattern,
// deframer states and the link status encoding derived from lock and sync errors.
package breakout_pkg;

    localparam int WORD_W     = 12;
    localparam int IDX_W      = 3;
    localparam int SYNC_ERR_W = 8;
    localparam logic [WORD_W-1:0] SYNC_WORD = 12'h100;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } deframer_state_t;

    typedef enum logic [1:0] {
        LINK_DOWN    = 2'd0,
        LINK_CLEAN   = 2'd1,
        LINK_ERRORED = 2'd2
    } link_status_t;

    function automatic link_status_t link_status_of(input logic locked,
                                                    input logic [SYNC_ERR_W-1:0] sync_err);
        if (!locked) begin
            return LINK_DOWN;
        end
        return (sync_err == '0) ? LINK_CLEAN : LINK_ERRORED;
    endfunction

endpackage

// File: rtl/bit_word_shifter.sv
// Serial-to-word shifter: MSB-first assembly with a word-boundary counter held at zero while hunting.
// Strobes are combinational off the current bit (0 clk); no backpressure, input qualified by bit_en only.
module bit_word_shifter
    import breakout_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              bit_en_i,
    input  logic              sdata_i,
    input  logic              hunt_i,
    output logic [WORD_W-1:0] next_word_o,
    output logic              word_done_o
);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;

    assign next_word_o = {sr_q[WORD_W-2:0], sdata_i};
    assign word_done_o = bit_en_i && !hunt_i && (bit_cnt_q == 4'(WORD_W - 1));

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (bit_en_i) begin
            sr_d = next_word_o;
            // While hunting the boundary is wherever the sync lands, so keep the count parked.
            if (hunt_i || word_done_o) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/lvds_word_deframer.sv
// Host-link word deframer: hunt/verify/lock on the sync word, emit indexed data words plus lock/error status.
// Outputs registered, 1 clk after the completing bit; no backpressure, one bit accepted per bit_en.
module lvds_word_deframer
    import breakout_pkg::*;
#(
    parameter int DATA_WORDS = 4,
    parameter int LOCK_SYNCS = 2,
    parameter int MISS_MAX   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_en,
    input  logic                  sdata,
    output logic [WORD_W-1:0]     word_data,
    output logic                  word_valid,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  frame_start,
    output logic                  locked,
    output logic [SYNC_ERR_W-1:0] sync_err
);

    localparam int SLOT_W = $clog2(DATA_WORDS + 1);
    localparam int OK_W   = $clog2(LOCK_SYNCS + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    deframer_state_t       state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [OK_W-1:0]       sync_ok_q, sync_ok_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic [WORD_W-1:0]     word_data_q, word_data_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic                  word_valid_q, word_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  locked_q, locked_d;
    logic [SYNC_ERR_W-1:0] sync_err_q, sync_err_d;

    logic [WORD_W-1:0] next_word;
    logic              word_done;
    logic              sync_hit;

    bit_word_shifter u_shifter (
        .clk_i       (clk),
        .reset_i     (reset),
        .bit_en_i    (bit_en),
        .sdata_i     (sdata),
        .hunt_i      (state_q == HUNT),
        .next_word_o (next_word),
        .word_done_o (word_done)
    );

    assign sync_hit = (next_word == SYNC_WORD);

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        sync_ok_d     = sync_ok_q;
        miss_d        = miss_q;
        word_data_d   = word_data_q;
        word_idx_d    = word_idx_q;
        word_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        locked_d      = locked_q;
        sync_err_d    = sync_err_q;

        case (state_q)
            HUNT: begin
                if (bit_en && sync_hit) begin
                    slot_d    = SLOT_W'(1);
                    sync_ok_d = OK_W'(1);
                    miss_d    = '0;
                    if (LOCK_SYNCS == 1) begin
                        state_d       = LOCKED;
                        locked_d      = 1'b1;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end
            default: begin
                if (word_done) begin
                    slot_d = (slot_q == SLOT_W'(DATA_WORDS)) ? '0 : slot_q + SLOT_W'(1);
                    if (slot_q == '0) begin
                        if (state_q == VERIFY) begin
                            if (sync_hit) begin
                                sync_ok_d = sync_ok_q + OK_W'(1);
                                if (sync_ok_q == OK_W'(LOCK_SYNCS - 1)) begin
                                    state_d       = LOCKED;
                                    locked_d      = 1'b1;
                                    frame_start_d = 1'b1;
                                end
                            end else begin
                                state_d   = HUNT;
                                sync_ok_d = '0;
                                slot_d    = '0;
                            end
                        end else if (sync_hit) begin
                            miss_d        = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            if (sync_err_q != '1) begin
                                sync_err_d = sync_err_q + SYNC_ERR_W'(1);
                            end
                            // Flywheel through isolated misses; only a run of them drops alignment.
                            if (miss_q == MISS_W'(MISS_MAX - 1)) begin
                                state_d  = HUNT;
                                locked_d = 1'b0;
                                miss_d   = '0;
                                slot_d   = '0;
                            end else begin
                                miss_d = miss_q + MISS_W'(1);
                            end
                        end
                    end else if (state_q == LOCKED) begin
                        word_valid_d = 1'b1;
                        word_data_d  = next_word;
                        word_idx_d   = IDX_W'(slot_q - SLOT_W'(1));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            sync_ok_q     <= '0;
            miss_q        <= '0;
            word_data_q   <= '0;
            word_idx_q    <= '0;
            word_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            sync_ok_q     <= sync_ok_d;
            miss_q        <= miss_d;
            word_data_q   <= word_data_d;
            word_idx_q    <= word_idx_d;
            word_valid_q  <= word_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_idx    = word_idx_q;
    assign word_valid  = word_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_lvds_word_deframer.sv
// Bench for lvds_word_deframer: directed link scenarios plus randomized framed traffic,
// all checked cycle by cycle against a bit-position model of the framing rules.
module tb_lvds_word_deframer;
    import breakout_pkg::*;

    localparam int DW = 4;
    localparam int LS = 2;
    localparam int MM = 3;
    localparam int FB = 12 * (DW + 1);

    typedef logic [11:0] wa_t [4];

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_en;
    logic        sdata;
    logic [11:0] word_data;
    logic        word_valid;
    logic [2:0]  word_idx;
    logic        frame_start;
    logic        locked;
    logic [7:0]  sync_err;

    lvds_word_deframer #(.DATA_WORDS(DW), .LOCK_SYNCS(LS), .MISS_MAX(MM)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_en      (bit_en),
        .sdata       (sdata),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_idx    (word_idx),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    logic [11:0] cap_dat[$];
    int          cap_idx[$];
    int          cap_cyc[$];

    wa_t DA = '{12'h7F0, 12'hA0F, 12'hFFF, 12'h100};
    wa_t DB = '{12'h7F0, 12'hA0F, 12'hFFF, 12'h5A5};
    localparam logic [11:0] CORR = 12'hE00;

    // Model state: mode 0=searching, 1=confirming, 2=aligned; pos = bits since the last sync ended.
    int          m_mode = 0;
    int          m_pos  = 0;
    int          m_good = 0;
    int          m_miss = 0;
    logic [11:0] m_sr   = '0;
    logic [11:0] exp_dat = '0;
    logic        exp_vld = 1'b0;
    logic [2:0]  exp_idx = '0;
    logic        exp_fs  = 1'b0;
    logic        exp_lck = 1'b0;
    logic [7:0]  exp_err = '0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic b);
        logic [11:0] w;
        w       = {m_sr[10:0], b};
        exp_vld = 1'b0;
        exp_fs  = 1'b0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_sr = '0;
            exp_dat = '0; exp_idx = '0; exp_lck = 1'b0; exp_err = '0;
        end else if (en) begin
            m_sr = w;
            if (m_mode == 0) begin
                if (w == SYNC_WORD) begin
                    m_pos  = 0;
                    m_good = 1;
                    if (m_good >= LS) begin
                        m_mode = 2; exp_lck = 1'b1; exp_fs = 1'b1;
                    end else begin
                        m_mode = 1;
                    end
                end
            end else begin
                m_pos = m_pos + 1;
                if (m_pos % 12 == 0) begin
                    if (m_pos < FB) begin
                        if (m_mode == 2) begin
                            exp_vld = 1'b1;
                            exp_dat = w;
                            exp_idx = 3'(m_pos / 12 - 1);
                        end
                    end else begin
                        m_pos = 0;
                        if (m_mode == 1) begin
                            if (w == SYNC_WORD) begin
                                m_good = m_good + 1;
                                if (m_good >= LS) begin
                                    m_mode = 2; exp_lck = 1'b1; exp_fs = 1'b1;
                                end
                            end else begin
                                m_mode = 0; m_good = 0;
                            end
                        end else if (w == SYNC_WORD) begin
                            m_miss = 0;
                            exp_fs = 1'b1;
                        end else begin
                            m_miss = m_miss + 1;
                            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                            if (m_miss >= MM) begin
                                m_mode = 0; m_miss = 0; exp_lck = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Compare process: outputs settle after each rising edge, checked 1 time unit later.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (chk_on) begin
            chk("word_valid",  int'(word_valid),  int'(exp_vld));
            chk("frame_start", int'(frame_start), int'(exp_fs));
            chk("locked",      int'(locked),      int'(exp_lck));
            chk("sync_err",    int'(sync_err),    int'(exp_err));
            chk("word_data",   int'(word_data),   int'(exp_dat));
            chk("word_idx",    int'(word_idx),    int'(exp_idx));
            if (word_valid) begin
                cap_dat.push_back(word_data);
                cap_idx.push_back(int'(word_idx));
                cap_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input logic en, input logic b);
        @(negedge clk);
        reset  = 1'b0;
        bit_en = en;
        sdata  = b;
        model_step(1'b0, en, b);
    endtask

    task automatic do_reset(input logic en);
        logic b;
        b = 1'($urandom);
        @(negedge clk);
        reset  = 1'b1;
        bit_en = en;
        sdata  = b;
        model_step(1'b1, en, b);
        chk_on = 1'b1;
    endtask

    task automatic send_word(input logic [11:0] w, input int gap);
        for (int i = 11; i >= 0; i--) begin
            repeat (gap) step(1'b0, 1'($urandom));
            step(1'b1, w[i]);
        end
    endtask

    task automatic send_frame(input logic [11:0] s, input wa_t d, input int gap);
        send_word(s, gap);
        for (int k = 0; k < 4; k++) send_word(d[k], gap);
    endtask

    task automatic clear_cap();
        cap_dat.delete();
        cap_idx.delete();
        cap_cyc.delete();
    endtask

    task automatic chk_words(input string name, input wa_t d, input int n);
        chk({name, "_count"}, cap_dat.size(), n);
        if (cap_dat.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({name, "_data"}, int'(cap_dat[i]), int'(d[i % 4]));
                chk({name, "_idx"},  cap_idx[i], i % 4);
            end
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_word_data"},   int'(word_data), 0);
        chk({name, "_word_valid"},  int'(word_valid), 0);
        chk({name, "_word_idx"},    int'(word_idx), 0);
        chk({name, "_frame_start"}, int'(frame_start), 0);
        chk({name, "_locked"},      int'(locked), 0);
        chk({name, "_sync_err"},    int'(sync_err), 0);
    endtask

    initial begin
        reset  = 1'b1;
        bit_en = 1'b0;
        sdata  = 1'b0;

        // Reset state
        do_reset(1'b1);
        do_reset(1'b0);
        step(1'b0, 1'b0);
        chk_zero_outputs("reset");

        // Framed data at full rate; lock on the second sync
        clear_cap();
        send_frame(SYNC_WORD, DA, 0);
        step(1'b0, 1'b0);
        chk("framed_unlocked_after_1", int'(locked), 0);
        send_word(SYNC_WORD, 0);
        step(1'b0, 1'b0);
        chk("framed_locked_at_2", int'(locked), 1);
        chk("framed_fs_at_2", int'(frame_start), 1);
        for (int k = 0; k < 4; k++) send_word(DA[k], 0);
        send_frame(SYNC_WORD, DA, 0);
        step(1'b0, 1'b0);
        chk_words("framed", DA, 8);
        if (cap_cyc.size() == 8) begin
            chk("framed_spacing_in_frame", cap_cyc[2] - cap_cyc[1], 12);
            chk("framed_spacing_over_sync", cap_cyc[4] - cap_cyc[3], 24);
        end

        // Sparse bit_en: one bit every 3 clks
        do_reset(1'b1);
        clear_cap();
        for (int f = 0; f < 3; f++) send_frame(SYNC_WORD, DA, 2);
        step(1'b0, 1'b0);
        chk("sparse_locked", int'(locked), 1);
        chk_words("sparse", DA, 8);
        if (cap_cyc.size() == 8) chk("sparse_spacing", cap_cyc[1] - cap_cyc[0], 36);

        // Sync loss: two misses flywheel, three drop lock
        clear_cap();
        send_frame(CORR, DB, 0);
        send_frame(CORR, DB, 0);
        step(1'b0, 1'b0);
        chk("loss2_sync_err", int'(sync_err), 2);
        chk("loss2_locked", int'(locked), 1);
        send_frame(SYNC_WORD, DB, 0);
        step(1'b0, 1'b0);
        chk_words("loss2_flow", DB, 12);
        send_frame(CORR, DB, 0);
        send_frame(CORR, DB, 0);
        send_word(CORR, 0);
        step(1'b0, 1'b0);
        chk("loss3_locked", int'(locked), 0);
        chk("loss3_sync_err", int'(sync_err), 5);
        for (int k = 0; k < 4; k++) send_word(DB[k], 0);
        send_frame(SYNC_WORD, DB, 0);
        send_word(SYNC_WORD, 0);
        step(1'b0, 1'b0);
        chk("relock_locked", int'(locked), 1);
        chk("relock_fs", int'(frame_start), 1);
        for (int k = 0; k < 4; k++) send_word(DB[k], 0);

        // Bit slip: one extra bit after lock
        step(1'b1, 1'b0);
        send_frame(SYNC_WORD, DB, 0);
        send_frame(SYNC_WORD, DB, 0);
        step(1'b0, 1'b0);
        chk("slip_locked_2", int'(locked), 1);
        chk("slip_sync_err_2", int'(sync_err), 7);
        send_word(SYNC_WORD, 0);
        step(1'b0, 1'b0);
        chk("slip_locked_3", int'(locked), 0);
        chk("slip_sync_err_3", int'(sync_err), 8);
        for (int k = 0; k < 4; k++) send_word(DB[k], 0);
        send_word(SYNC_WORD, 0);
        step(1'b0, 1'b0);
        chk("slip_relocked", int'(locked), 1);
        clear_cap();
        for (int k = 0; k < 4; k++) send_word(DB[k], 0);
        step(1'b0, 1'b0);
        chk_words("slip_resume", DB, 4);

        // Reset at bit 5 of the second data word
        send_word(SYNC_WORD, 0);
        send_word(DB[0], 0);
        for (int i = 11; i >= 7; i--) step(1'b1, DB[1][i]);
        do_reset(1'b1);
        step(1'b0, 1'b0);
        chk_zero_outputs("midreset");
        clear_cap();
        for (int i = 6; i >= 0; i--) step(1'b1, DB[1][i]);
        send_word(DB[2], 0);
        send_word(DB[3], 0);
        send_frame(SYNC_WORD, DB, 0);
        step(1'b0, 1'b0);
        chk("midreset_no_words", cap_dat.size(), 0);
        chk("midreset_unlocked", int'(locked), 0);
        chk("midreset_sync_err", int'(sync_err), 0);
        send_frame(SYNC_WORD, DB, 0);
        step(1'b0, 1'b0);
        chk("midreset_relocked", int'(locked), 1);
        chk_words("midreset_resume", DB, 4);

        // Randomized traffic: corrupt syncs, slips, sync-like data, variable bit rate
        for (int r = 0; r < 6; r++) begin
            do_reset(1'($urandom));
            for (int f = 0; f < 12; f++) begin
                int          gap;
                logic [11:0] s;
                wa_t         d;
                gap = $urandom_range(0, 2);
                s = ($urandom_range(0, 4) == 0) ? (SYNC_WORD ^ 12'(1 << $urandom_range(0, 11)))
                                                : SYNC_WORD;
                for (int k = 0; k < 4; k++) begin
                    d[k] = ($urandom_range(0, 7) == 0) ? SYNC_WORD : 12'($urandom);
                end
                if ($urandom_range(0, 7) == 0) begin
                    for (int j = 0; j < int'($urandom_range(1, 2)); j++) step(1'b1, 1'($urandom));
                end
                if ($urandom_range(0, 19) == 0) do_reset(1'($urandom));
                send_frame(s, d, gap);
            end
        end

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
